// File: rtl/fsm_piso_pkg.sv
// Shared types and constants for the 4-floor elevator controller.
package fsm_piso_pkg;

  typedef enum logic [2:0] {
    REPOSO   = 3'b000,
    ABIERTO  = 3'b001,
    LISTO    = 3'b010,
    MOVIENDO = 3'b011,
    LLEGADA  = 3'b100
  } state_t;

  localparam logic [3:0] FLOOR0   = 4'b0001;
  localparam logic       DIR_UP   = 1'b1;
  localparam logic       DIR_DOWN = 1'b0;

endpackage

// File: rtl/fsm_piso_selector.sv
// SCAN target selection: keep travelling in the current direction while
// there is work that way, otherwise reverse. Purely combinational.
module fsm_piso_selector
  import fsm_piso_pkg::*;
(
  input  logic [3:0] actual,
  input  logic [3:0] pend,
  input  logic       dir,
  output logic [3:0] target,
  output logic       new_dir,
  output logic       valid
);

  int         act_idx;
  logic       up_hit;
  logic       dn_hit;
  logic [1:0] up_idx;
  logic [1:0] dn_idx;

  // nearest pending floor strictly above and strictly below the car
  always_comb begin
    act_idx = 0;
    for (int i = 0; i < 4; i++) begin
      if (actual[i]) act_idx = i;
    end
    up_hit = 1'b0;
    up_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend[i] && (i > act_idx)) begin
        up_hit = 1'b1;
        up_idx = 2'(i);
      end
    end
    dn_hit = 1'b0;
    dn_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (pend[i] && (i < act_idx)) begin
        dn_hit = 1'b1;
        dn_idx = 2'(i);
      end
    end
  end

  // prefer the current direction; fall back to the opposite one and flip dir
  always_comb begin
    target  = actual;
    new_dir = dir;
    valid   = 1'b0;
    if (dir == DIR_UP) begin
      if (up_hit) begin
        target = FLOOR0 << up_idx;
        valid  = 1'b1;
      end else if (dn_hit) begin
        target  = FLOOR0 << dn_idx;
        new_dir = DIR_DOWN;
        valid   = 1'b1;
      end
    end else begin
      if (dn_hit) begin
        target = FLOOR0 << dn_idx;
        valid  = 1'b1;
      end else if (up_hit) begin
        target  = FLOOR0 << up_idx;
        new_dir = DIR_UP;
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsm_piso.sv
// Elevator car control FSM: latches floor calls, tracks the door, and
// drives the car to a SCAN-selected target until the shaft reports arrival.
//
// state    | meaning
// REPOSO   | idle, door closed, no pending calls
// ABIERTO  | door open
// LISTO    | door closed, calls pending, waiting for accion
// MOVIENDO | travelling to siguiente, waiting for llego rising edge
// LLEGADA  | arrived at siguiente
module fsm_piso
  import fsm_piso_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] piso,
  input  logic       puerta,
  input  logic       accion,
  input  logic       llego,
  output logic [2:0] estado,
  output logic [3:0] siguiente
);

  state_t     state;
  state_t     state_nx;
  logic [3:0] actual;
  logic [3:0] pend;
  logic       dir;
  logic       llego_q;
  logic [3:0] sel_target;
  logic       sel_dir;
  logic       sel_valid;
  logic       pend_any;
  logic       llego_rise;
  logic       go;
  logic       done;

  assign pend_any   = |pend;
  assign llego_rise = llego & ~llego_q;
  assign estado     = state;

  fsm_piso_selector u_selector (
    .actual  (actual),
    .pend    (pend),
    .dir     (dir),
    .target  (sel_target),
    .new_dir (sel_dir),
    .valid   (sel_valid)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= REPOSO;
    else     state <= state_nx;
  end

  // next-state logic; illegal codes fall back to REPOSO
  always_comb begin
    state_nx = state;
    case (state)
      REPOSO: begin
        if (puerta)        state_nx = ABIERTO;
        else if (pend_any) state_nx = LISTO;
      end
      ABIERTO: begin
        if (!puerta) state_nx = pend_any ? LISTO : REPOSO;
      end
      LISTO: begin
        if (puerta)                   state_nx = ABIERTO;
        else if (!pend_any)           state_nx = REPOSO;
        else if (accion && sel_valid) state_nx = MOVIENDO;
      end
      MOVIENDO: begin
        if (llego_rise) state_nx = LLEGADA;
      end
      LLEGADA: begin
        if (puerta)                  state_nx = ABIERTO;
        else if (pend_any && accion) state_nx = LISTO;
      end
      default: state_nx = REPOSO;
    endcase
  end

  // control strobes for the datapath: departure and completed travel
  always_comb begin
    go   = (state == LISTO) && (state_nx == MOVIENDO);
    done = (state == MOVIENDO) && llego_rise;
  end

  // request set, car position, direction, target and arrival edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      siguiente <= FLOOR0;
      actual    <= FLOOR0;
      pend      <= 4'b0000;
      dir       <= DIR_UP;
      llego_q   <= 1'b0;
    end else begin
      llego_q <= llego;
      if (go) begin
        siguiente <= sel_target;
        dir       <= sel_dir;
      end
      if (done) begin
        actual <= siguiente;
        pend   <= (pend | piso) & ~siguiente;
      end else if (state != MOVIENDO) begin
        pend <= (pend | piso) & ~actual;
      end else begin
        pend <= pend | piso;
      end
    end
  end

endmodule

// File: tb/tb_fsm_piso.sv
// Bench for fsm_piso: directed vector table followed by random traffic
// checked against a floor-number reference model.
module tb_fsm_piso;

  logic       clk;
  logic       rst;
  logic [3:0] piso;
  logic       puerta;
  logic       accion;
  logic       llego;
  logic [2:0] estado;
  logic [3:0] siguiente;

  int checks   = 0;
  int failures = 0;

  fsm_piso dut (
    .clk       (clk),
    .rst       (rst),
    .piso      (piso),
    .puerta    (puerta),
    .accion    (accion),
    .llego     (llego),
    .estado    (estado),
    .siguiente (siguiente)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       r;
    bit [3:0] p;
    bit       pu;
    bit       ac;
    bit       ll;
    bit [2:0] est;
    bit [3:0] sig;
  } vec_t;

  vec_t tbl[$];

  // reference model: floors as integers 0..3, state as plain numbers
  int       m_st;
  int       m_sig;
  int       m_act;
  bit [3:0] m_pend;
  bit       m_up;
  bit       m_lq;

  task automatic add(input bit r, input bit [3:0] p, input bit pu, input bit ac,
                     input bit ll, input bit [2:0] est, input bit [3:0] sig);
    vec_t v;
    v.r = r; v.p = p; v.pu = pu; v.ac = ac; v.ll = ll; v.est = est; v.sig = sig;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input bit [3:0] act, input bit [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  // search outward from the car, first in the travel direction, then the other
  task automatic pick(output int tgt, output bit ok, output bit nup);
    int f;
    tgt = m_act; ok = 1'b0; nup = m_up;
    for (int d = 1; d < 4; d++) begin
      f = m_up ? m_act + d : m_act - d;
      if (!ok && f >= 0 && f < 4 && m_pend[f]) begin tgt = f; ok = 1'b1; end
    end
    for (int d = 1; d < 4; d++) begin
      f = m_up ? m_act - d : m_act + d;
      if (!ok && f >= 0 && f < 4 && m_pend[f]) begin tgt = f; ok = 1'b1; nup = !m_up; end
    end
  endtask

  task automatic model_step(input bit r, input bit [3:0] p, input bit pu, input bit ac, input bit ll);
    bit       ev;
    int       tgt;
    bit       ok;
    bit       nup;
    bit [3:0] np;
    int       nst;
    if (r) begin
      m_st = 0; m_sig = 0; m_act = 0; m_pend = 4'b0000; m_up = 1'b1; m_lq = 1'b0;
      return;
    end
    ev   = ll && !m_lq;
    m_lq = ll;
    pick(tgt, ok, nup);
    np  = m_pend | p;
    nst = m_st;
    case (m_st)
      0: if (pu) nst = 1; else if (m_pend != 0) nst = 2;
      1: if (!pu) nst = (m_pend != 0) ? 2 : 0;
      2: begin
        if (pu) nst = 1;
        else if (m_pend == 0) nst = 0;
        else if (ac && ok) begin nst = 3; m_sig = tgt; m_up = nup; end
      end
      3: if (ev) begin nst = 4; m_act = m_sig; np[m_sig] = 1'b0; end
      4: if (pu) nst = 1; else if (m_pend != 0 && ac) nst = 2;
      default: nst = 0;
    endcase
    if (m_st != 3) np[m_act] = 1'b0;
    m_pend = np;
    m_st   = nst;
  endtask

  task automatic apply(input bit r, input bit [3:0] p, input bit pu, input bit ac, input bit ll);
    rst = r; piso = p; puerta = pu; accion = ac; llego = ll;
    @(posedge clk);
    model_step(r, p, pu, ac, ll);
    #1;
  endtask

  initial begin
    rst = 1'b1; piso = 4'b0; puerta = 1'b0; accion = 1'b0; llego = 1'b0;
    m_st = 0; m_sig = 0; m_act = 0; m_pend = 4'b0; m_up = 1'b1; m_lq = 1'b0;

    //   rst piso    pu ac ll  estado  siguiente
    add(1, 4'b0000, 0, 0, 0, 3'b000, 4'b0001); // reset
    add(0, 4'b0000, 0, 0, 0, 3'b000, 4'b0001);
    add(0, 4'b0000, 0, 0, 0, 3'b000, 4'b0001);
    add(0, 4'b0000, 0, 0, 0, 3'b000, 4'b0001);
    add(0, 4'b0000, 1, 0, 0, 3'b001, 4'b0001); // door opens
    add(0, 4'b0100, 1, 0, 0, 3'b001, 4'b0001); // call floor 2
    add(0, 4'b0000, 0, 0, 0, 3'b010, 4'b0001); // door closes
    add(0, 4'b0000, 0, 1, 0, 3'b011, 4'b0100); // depart
    add(0, 4'b0000, 0, 0, 1, 3'b100, 4'b0100); // arrive
    add(0, 4'b0000, 1, 0, 0, 3'b001, 4'b0100);
    add(0, 4'b0000, 0, 0, 0, 3'b000, 4'b0100); // floor 2 served
    add(1, 4'b0000, 0, 0, 0, 3'b000, 4'b0001); // SCAN up
    add(0, 4'b1100, 0, 0, 0, 3'b000, 4'b0001);
    add(0, 4'b0000, 0, 1, 0, 3'b010, 4'b0001);
    add(0, 4'b0000, 0, 1, 0, 3'b011, 4'b0100);
    add(0, 4'b0000, 0, 0, 1, 3'b100, 4'b0100);
    add(0, 4'b0000, 0, 1, 0, 3'b010, 4'b0100);
    add(0, 4'b0000, 0, 1, 0, 3'b011, 4'b1000);
    add(0, 4'b0000, 0, 0, 1, 3'b100, 4'b1000);
    add(0, 4'b0010, 0, 0, 0, 3'b100, 4'b1000); // reversal
    add(0, 4'b0000, 0, 1, 0, 3'b010, 4'b1000);
    add(0, 4'b0000, 0, 1, 0, 3'b011, 4'b0010);
    add(0, 4'b0000, 0, 0, 1, 3'b100, 4'b0010);
    add(0, 4'b0001, 0, 0, 1, 3'b100, 4'b0010); // level llego
    add(0, 4'b0000, 0, 1, 1, 3'b010, 4'b0010);
    add(0, 4'b0000, 0, 1, 1, 3'b011, 4'b0001);
    add(0, 4'b0000, 0, 0, 1, 3'b011, 4'b0001);
    add(0, 4'b0000, 1, 1, 1, 3'b011, 4'b0001);
    add(0, 4'b0000, 0, 0, 0, 3'b011, 4'b0001);
    add(0, 4'b0000, 0, 0, 1, 3'b100, 4'b0001);
    add(0, 4'b1000, 0, 0, 0, 3'b100, 4'b0001); // reset mid-travel
    add(0, 4'b0000, 0, 1, 0, 3'b010, 4'b0001);
    add(0, 4'b0000, 0, 1, 0, 3'b011, 4'b1000);
    add(1, 4'b0000, 0, 0, 1, 3'b000, 4'b0001);
    add(0, 4'b0000, 0, 0, 0, 3'b000, 4'b0001);
    add(0, 4'b0010, 0, 0, 0, 3'b000, 4'b0001); // door beats accion
    add(0, 4'b0000, 0, 0, 0, 3'b010, 4'b0001);
    add(0, 4'b0000, 1, 1, 0, 3'b001, 4'b0001);
    add(0, 4'b0000, 0, 0, 0, 3'b010, 4'b0001);
    add(0, 4'b0000, 0, 1, 0, 3'b011, 4'b0010); // clear beats press
    add(0, 4'b0010, 0, 0, 1, 3'b100, 4'b0010);
    add(0, 4'b0000, 0, 1, 0, 3'b100, 4'b0010);
    add(0, 4'b0010, 0, 0, 0, 3'b100, 4'b0010); // call at current floor
    add(0, 4'b0000, 0, 1, 0, 3'b100, 4'b0010);

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].p, tbl[i].pu, tbl[i].ac, tbl[i].ll);
      check("dir_estado", i, {1'b0, estado}, {1'b0, tbl[i].est});
      check("dir_siguiente", i, siguiente, tbl[i].sig);
    end

    apply(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      bit       r;
      bit [3:0] p;
      r = ($urandom_range(99) == 0);
      p = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'b0000;
      apply(r, p, ($urandom_range(9) == 0), 1'($urandom_range(1)), ($urandom_range(2) == 0));
      check("rnd_estado", n, {1'b0, estado}, 4'(m_st));
      check("rnd_siguiente", n, siguiente, 4'(1 << m_sig));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
